// File: rtl/aes_pkg.sv
// Shared AES package: block/key widths, the output serializer FSM state
// type, and the AES core's own control-state encoding.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_KEY_W   = 128;

  // Output serializer control FSM
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // AES core control FSM
  typedef enum logic [1:0] {
    CORE_IDLE   = 2'd0,
    CORE_KEYEXP = 2'd1,
    CORE_ROUND  = 2'd2,
    CORE_DONE   = 2'd3
  } aes_core_state_t;

endpackage

// File: rtl/block_fifo.sv
// block_fifo: DEPTH x 128-bit synchronous FIFO for AES result blocks.
//   clk, rst_n     : clock, asynchronous active-low reset (control only)
//   push, din      : write din at the tail (caller guarantees room or a
//                    same-cycle pop)
//   pop            : release the head block (caller guarantees non-empty)
//   head           : block at the head of the queue
//   level          : number of blocks held
//   full, empty    : level == DEPTH / level == 0
module block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [AES_BLOCK_W-1:0] din,
  output logic [AES_BLOCK_W-1:0] head,
  output logic [LW-1:0]          level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AES_BLOCK_W-1:0] mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/aes_out_serializer.sv
// aes_out_serializer: captures 128-bit AES result blocks on done_i,
// buffers up to DEPTH of them and streams each out as 128/WORD_W words,
// most-significant word first, over a valid/ready handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   block_i      : result block, sampled when done_i=1
//   done_i       : one-cycle completion strobe from the core
//   word_o       : current output word (0 while nothing is buffered)
//   valid_o      : word_o is valid
//   ready_i      : consumer takes word_o this cycle
//   last_o       : word_o is the final word of its block
//   level_o      : blocks held, including the one being sent
//   overflow_o   : sticky, a block arrived while the buffer was full
// WORD_W must divide 128; DEPTH must be at least 1.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [AES_BLOCK_W-1:0]       block_i,
  input  logic                         done_i,
  output logic [WORD_W-1:0]            word_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         last_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         overflow_o
);

  localparam int NW = AES_BLOCK_W / WORD_W;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  ser_state_t             state, state_nxt;
  logic [IW-1:0]          idx;
  logic [AES_BLOCK_W-1:0] head;
  logic [LW-1:0]          fifo_level;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   word_pop;
  logic                   blk_pop;
  logic                   push;
  logic                   idx_last;
  logic [WORD_W-1:0]      word_sel;

  assign valid_o  = (state == SEND);
  assign idx_last = (idx == IW'(NW - 1));
  assign word_pop = valid_o && ready_i && !fifo_empty;
  assign blk_pop  = word_pop && idx_last;
  // A full buffer still accepts a block if its head leaves this cycle.
  assign push     = done_i && (!fifo_full || blk_pop);

  block_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (blk_pop),
    .din   (block_i),
    .head  (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      overflow_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (word_pop) idx <= idx_last ? '0 : idx + IW'(1);
      if (done_i && fifo_full && !blk_pop) overflow_o <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (push) state_nxt = SEND;
      SEND: if (blk_pop && !push && fifo_level == LW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word k sits at bits [127-k*WORD_W -: WORD_W]; address it directly
  // from the index instead of shifting the block.
  always_comb begin
    word_sel = head[(NW - 1 - int'(idx)) * WORD_W +: WORD_W];
  end

  assign word_o  = valid_o ? word_sel : '0;
  assign last_o  = valid_o && idx_last;
  assign level_o = fifo_level;

endmodule

// File: tb/tb_aes_out_serializer.sv
module tb_aes_out_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] block_i;
  logic         done_i;
  logic [31:0]  word_o;
  logic         valid_o;
  logic         ready_i;
  logic         last_o;
  logic [1:0]   level_o;
  logic         overflow_o;

  logic [127:0] blk8;
  logic         done8;
  logic [7:0]   word8;
  logic         valid8;
  logic         ready8;
  logic         last8;
  logic [1:0]   level8;
  logic         ovf8;

  int ncmp = 0;
  int nerr = 0;

  // Scoreboard: expected words in emission order
  logic [31:0] q[$];
  int          mlev = 0;
  int          midx = 0;
  logic        movf = 1'b0;

  localparam logic [127:0] T = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] C = 128'hcafef00d111122223333444455556666;
  localparam logic [127:0] N = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] D = 128'ha5a5a5a55a5a5a5a3c3c3c3cc3c3c3c3;

  aes_out_serializer #(.WORD_W(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .block_i    (block_i),
    .done_i     (done_i),
    .word_o     (word_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  aes_out_serializer #(.WORD_W(8), .DEPTH(2)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .block_i    (blk8),
    .done_i     (done8),
    .word_o     (word8),
    .valid_o    (valid8),
    .ready_i    (ready8),
    .last_o     (last8),
    .level_o    (level8),
    .overflow_o (ovf8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mlev = 0;
    midx = 0;
    movf = 1'b0;
  endtask

  // Check current outputs against the model, drive the next inputs,
  // advance the model across the coming edge, and wait for it.
  task automatic cycle(input logic rdy, input logic dn, input logic [127:0] blk);
    logic pop_w, blk_pop, acc, ovf;
    chk("valid", {127'd0, valid_o}, {127'd0, mlev != 0});
    chk("level", {126'd0, level_o}, 128'(mlev));
    chk("overflow", {127'd0, overflow_o}, {127'd0, movf});
    if (mlev != 0 && q.size() > 0) begin
      chk("word", {96'd0, word_o}, {96'd0, q[0]});
      chk("last", {127'd0, last_o}, {127'd0, midx == 3});
    end
    ready_i = rdy;
    done_i  = dn;
    block_i = blk;
    pop_w   = (mlev != 0) && rdy;
    blk_pop = pop_w && (midx == 3);
    acc     = dn && (mlev < 2 || blk_pop);
    ovf     = dn && (mlev == 2) && !blk_pop;
    if (pop_w) begin
      void'(q.pop_front());
      midx = blk_pop ? 0 : midx + 1;
    end
    if (acc) begin
      for (int k = 0; k < 4; k++) q.push_back(32'(blk >> (96 - 32 * k)));
    end
    mlev = mlev + (acc ? 1 : 0) - (blk_pop ? 1 : 0);
    if (ovf) movf = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    block_i = '0;
    done_i  = 1'b0;
    ready_i = 1'b0;
    blk8    = '0;
    done8   = 1'b0;
    ready8  = 1'b0;
    #12;
    // reset state
    chk("rst_valid", {127'd0, valid_o}, 128'd0);
    chk("rst_last", {127'd0, last_o}, 128'd0);
    chk("rst_level", {126'd0, level_o}, 128'd0);
    chk("rst_overflow", {127'd0, overflow_o}, 128'd0);
    chk("rst_word", {96'd0, word_o}, 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single block, ready held high
    cycle(1'b1, 1'b1, T);
    chk("t1_word0", {96'd0, word_o}, {96'd0, 32'h69c4e0d8});
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0);

    // backpressure: ready 1,0,0,1,0,0,...
    cycle(1'b0, 1'b1, T);
    for (int i = 0; i < 12; i++) cycle(i % 3 == 0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);

    // simultaneous push/pop at full
    cycle(1'b0, 1'b1, A);
    cycle(1'b0, 1'b1, B);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, N);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, '0);

    // fill and overflow
    cycle(1'b0, 1'b1, A);
    cycle(1'b0, 1'b1, B);
    cycle(1'b0, 1'b1, C);
    cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, '0);

    // reset mid-stream after two words of A
    cycle(1'b1, 1'b1, A);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    #2;
    rst_n   = 1'b0;
    ready_i = 1'b0;
    #1;
    chk("arst_valid", {127'd0, valid_o}, 128'd0);
    chk("arst_level", {126'd0, level_o}, 128'd0);
    chk("arst_overflow", {127'd0, overflow_o}, 128'd0);
    model_reset();
    done_i  = 1'b1;
    block_i = C;
    @(posedge clk);
    #1;
    chk("rst_done_ignored", {126'd0, level_o}, 128'd0);
    done_i = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b1, D);
    chk("d_word0", {96'd0, word_o}, {96'd0, 32'ha5a5a5a5});
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0);

    // WORD_W=8 build
    ready8 = 1'b1;
    done8  = 1'b1;
    blk8   = T;
    @(posedge clk);
    #1;
    done8 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("b8_valid", {127'd0, valid8}, 128'd1);
      chk("b8_word", {120'd0, word8}, {120'd0, 8'(T >> (120 - 8 * k))});
      chk("b8_last", {127'd0, last8}, {127'd0, k == 15});
      @(posedge clk);
      #1;
    end
    chk("b8_idle", {127'd0, valid8}, 128'd0);
    chk("b8_level", {126'd0, level8}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
# aes_out_serializer

Downstream stage of the AES-128 core. It captures each 128-bit result block when the core pulses `done`, buffers up to DEPTH blocks, and streams them out as WORD_W-bit words over a valid/ready handshake, most-significant word first. It decouples the core's one-cycle `done` strobe from a slower consumer such as a bus or UART packer, and reports dropped blocks.

## Interface
- WORD_W, 32, output word width; must divide 128 (legal: 8, 16, 32, 64, 128).
- DEPTH, 2, number of 128-bit blocks buffered; must be ≥1.
- clk  in  1  rising-edge clock shared with the AES core.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- block_i  in  128  result block from the core (`ciphertext`), sampled only when done_i=1.
- done_i  in  1  one-cycle strobe from the core's `done` output.
- word_o  out  WORD_W  current output word.
- valid_o  out  1  word_o is valid.
- ready_i  in  1  consumer accepts word_o this cycle.
- last_o  out  1  word_o is the final word of its block; meaningful only with valid_o.
- level_o  out  $clog2(DEPTH+1)  number of blocks held, including the partially sent one.
- overflow_o  out  1  sticky; set when a block was dropped.

## Operation
- NW = 128/WORD_W words per block; word k = block[127-k*WORD_W -: WORD_W], k = 0..NW-1.
- Push: when done_i=1, block_i is written at the tail if level<DEPTH, or if level=DEPTH and a pop occurs in the same cycle.
- Pop: a transfer occurs when valid_o=1 and ready_i=1. It advances the word index; on word NW-1, the head block is released and the index returns to 0.
- valid_o = (level≠0). last_o = valid_o && (index == NW-1).
- Control FSM:
  - IDLE (level=0) → SEND on push.
  - SEND → IDLE when the last word pops with no simultaneous push and level=1.
  - Otherwise it stays in SEND.
- Overflow: done_i=1 while level=DEPTH and no pop in the same cycle. The block is discarded, buffer contents and index are unchanged, and overflow_o latches 1 until reset.
- Simultaneous push+pop: level is unchanged, the new block goes to the tail, and the head advances.
- word_o and last_o hold stable while valid_o=1 and ready_i=0.
- ready_i is ignored while valid_o=0.
- Pointers wrap modulo DEPTH. The word index wraps modulo NW.

## Timing
- All outputs are registered or derived from registered state. There is no combinational path from ready_i or done_i to any output.
- Latency: done_i at edge N → valid_o=1 and word 0 on word_o after edge N (available in cycle N+1).
- Throughput: one word per cycle with ready_i held high. Back-to-back blocks stream with no bubble.
- Reset values: valid_o=0, last_o=0, level_o=0, overflow_o=0, word_o=0.
- Reset asserted mid-block drops all buffered data and the word index immediately (asynchronous). The buffer storage itself need not be cleared.
- done_i asserted during reset is ignored.

## Structure
- Shared package `aes_pkg`: AES_BLOCK_W=128, AES_KEY_W=128, and the FSM state typedef {IDLE, SEND}. The AES core's own state encodings also belong there.
- One sub-module: `block_fifo`, a DEPTH×128 synchronous FIFO with push, pop, level, full and empty. The serializer adds the word index, word mux, FSM and overflow flag.
- The word mux is a shift-free indexed part-select driven by the index register.

## Test plan
- Single block, ready_i=1: done_i with block_i=128'h69c4e0d86a7b0430d8cdb78070b4c55a → next four cycles word_o = 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; last_o only on the 4th word; then valid_o=0 and level_o=0.
- Backpressure: same block, ready_i toggling 1,0,0,1,… → each word is held stable during stalls; 4 transfers in total, in order.
- Fill and overflow (DEPTH=2, ready_i=0): three done_i pulses with blocks A, B, C → level_o=2, overflow_o=1; then ready_i=1 → the eight words of A then B are emitted; C is never emitted.
- Simultaneous push/pop at full: level=2, ready_i=1, and done_i coincides with A's last word → no overflow; output order is A, B, new block.
- Reset mid-stream: assert rst_n=0 after 2 words of A → valid_o, level_o and overflow_o fall to 0 asynchronously. After release, a new block D streams from word 0.
- WORD_W=8 build: one block → 16 bytes out, MSB first (69, c4, …, 5a); last_o on byte 16.
